// File: rtl/dma_bus_if.sv
// dma_bus_if: shared-bus signal bundle between a DMA bus master and the bus slave/arbiter side
interface dma_bus_if;
    logic        request;
    logic        granted;
    logic        begin_trans_out;
    logic [31:0] addr_data_out;
    logic [7:0]  burst_size_out;
    logic        read_n_write;
    logic        data_valid_out;
    logic        end_trans_out;
    logic [31:0] addr_data_in;
    logic        data_valid_in;
    logic        busy_in;
    logic        end_trans_in;
    logic        error_in;
    modport master (
        output request, begin_trans_out, addr_data_out, burst_size_out,
               read_n_write, data_valid_out, end_trans_out,
        input  granted, addr_data_in, data_valid_in, busy_in, end_trans_in, error_in
    );
    modport slave (
        input  request, begin_trans_out, addr_data_out, burst_size_out,
               read_n_write, data_valid_out, end_trans_out,
        output granted, addr_data_in, data_valid_in, busy_in, end_trans_in, error_in
    );
endinterface

// File: rtl/dma_bus_master.sv
// dma_bus_master: moves a block of words in bursts between the shared bus and local CI memory
module dma_bus_master #(
    parameter int MEM_AW = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              dir,
    input  logic [31:0]       bus_start_addr,
    input  logic [MEM_AW-1:0] mem_start_addr,
    input  logic [9:0]        block_size,
    input  logic [7:0]        burst_size,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    dma_bus_if.master         bus
);
    typedef enum logic [3:0] {IDLE, REQ, BEGIN, RD_DATA, WR_FETCH, WR_DATA, WR_END, NEXT, DONE} state_t;
    state_t            state_q, state_d;
    logic              dir_q, error_q, fresh_q, accept, abort;
    logic [31:0]       bus_addr_q, hold_q, word;
    logic [MEM_AW-1:0] ptr_q, ptr_inc;
    logic [9:0]        remaining_q, cnt_q, burst_words, n;
    logic [7:0]        burst_q;
    assign burst_words = {2'b00, burst_q} + 10'd1;
    assign n           = burst_words < remaining_q ? burst_words : remaining_q;
    assign ptr_inc     = ptr_q + MEM_AW'(1);
    // fresh_q: memory output still holds the word read last cycle; otherwise it was captured on a stall
    assign word        = fresh_q ? mem_rdata : hold_q;
    assign accept      = state_q == WR_DATA && !bus.busy_in;
    assign abort       = bus.error_in && state_q != IDLE && state_q != DONE;
    assign busy        = state_q != IDLE;
    assign done        = state_q == DONE;
    assign error       = error_q;
    // state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end
    // next state and bus/memory outputs; a bus error overrides everything and aborts
    always_comb begin
        state_d             = state_q;
        bus.request         = 1'b0;
        bus.begin_trans_out = 1'b0;
        bus.addr_data_out   = '0;
        bus.burst_size_out  = '0;
        bus.read_n_write    = 1'b0;
        bus.data_valid_out  = 1'b0;
        bus.end_trans_out   = 1'b0;
        mem_addr            = '0;
        mem_we              = 1'b0;
        mem_wdata           = '0;
        case (state_q)
            IDLE: if (start) state_d = block_size == 10'd0 ? DONE : REQ;
            REQ: begin
                bus.request = 1'b1;
                if (bus.granted) state_d = BEGIN;
            end
            BEGIN: begin
                bus.request         = 1'b1;
                bus.begin_trans_out = 1'b1;
                bus.addr_data_out   = bus_addr_q;
                bus.burst_size_out  = 8'(n - 10'd1);
                bus.read_n_write    = ~dir_q;
                state_d             = dir_q ? WR_FETCH : RD_DATA;
            end
            RD_DATA: begin
                bus.request = 1'b1;
                mem_we      = bus.data_valid_in;
                mem_addr    = ptr_q;
                mem_wdata   = bus.addr_data_in;
                if (bus.end_trans_in) state_d = NEXT;
            end
            WR_FETCH: begin
                bus.request = 1'b1;
                mem_addr    = ptr_q;
                state_d     = WR_DATA;
            end
            WR_DATA: begin
                bus.request        = 1'b1;
                bus.data_valid_out = 1'b1;
                bus.addr_data_out  = word;
                mem_addr           = ptr_inc;
                if (accept && cnt_q + 10'd1 == n) state_d = WR_END;
            end
            WR_END: begin
                bus.request       = 1'b1;
                bus.end_trans_out = 1'b1;
                state_d           = NEXT;
            end
            NEXT: state_d = remaining_q == n ? DONE : REQ;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d             = DONE;
            bus.request         = 1'b0;
            bus.begin_trans_out = 1'b0;
            bus.addr_data_out   = '0;
            bus.burst_size_out  = '0;
            bus.read_n_write    = 1'b0;
            bus.data_valid_out  = 1'b0;
            bus.end_trans_out   = state_q == WR_DATA;
            mem_we              = 1'b0;
        end
    end
    // transfer configuration, pointers, burst progress and sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            dir_q       <= 1'b0;
            error_q     <= 1'b0;
            fresh_q     <= 1'b0;
            bus_addr_q  <= '0;
            hold_q      <= '0;
            ptr_q       <= '0;
            remaining_q <= '0;
            cnt_q       <= '0;
            burst_q     <= '0;
        end else if (abort) begin
            error_q <= 1'b1;
        end else begin
            if (state_q == IDLE && start) begin
                dir_q       <= dir;
                error_q     <= 1'b0;
                bus_addr_q  <= bus_start_addr & ~32'd3;
                ptr_q       <= mem_start_addr;
                remaining_q <= block_size;
                burst_q     <= burst_size;
            end
            if (state_q == BEGIN) cnt_q <= '0;
            if (state_q == RD_DATA && bus.data_valid_in) ptr_q <= ptr_inc;
            if (state_q == WR_FETCH) fresh_q <= 1'b1;
            if (state_q == WR_DATA) begin
                if (accept) begin
                    ptr_q   <= ptr_inc;
                    cnt_q   <= cnt_q + 10'd1;
                    fresh_q <= 1'b1;
                end else begin
                    hold_q  <= word;
                    fresh_q <= 1'b0;
                end
            end
            if (state_q == NEXT) begin
                bus_addr_q  <= bus_addr_q + {20'd0, n, 2'b00};
                remaining_q <= remaining_q - n;
            end
        end
    end
endmodule

// File: tb/tb_dma_bus_master.sv
// tb_dma_bus_master: scoreboard bench with bus slave and memory models around dma_bus_master
module tb_dma_bus_master;
    logic        clock = 1'b0;
    logic        reset, start, dir;
    logic [31:0] bus_start_addr;
    logic [8:0]  mem_start_addr;
    logic [9:0]  block_size;
    logic [7:0]  burst_size;
    logic        busy, done, error, mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] mem [512];
    dma_bus_if bus();
    dma_bus_master #(.MEM_AW(9)) dut (
        .clock(clock), .reset(reset), .start(start), .dir(dir),
        .bus_start_addr(bus_start_addr), .mem_start_addr(mem_start_addr),
        .block_size(block_size), .burst_size(burst_size),
        .busy(busy), .done(done), .error(error),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .bus(bus)
    );
    always #5 clock = ~clock;
    assign bus.granted = bus.request;
    int checks = 0, errors = 0;
    int et_cnt = 0, gap_cnt = 0, req_cnt = 0, stall_chk = 0;
    int wr_acc = 0, stall_k = -1, err_burst = -1, rd_burst = 0;
    logic [40:0] beg_q [$];
    logic [40:0] mw_q [$];
    logic [31:0] wd_q [$];
    logic        de_q [$];
    function automatic logic [31:0] f(logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction
    task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic extra(string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event with nothing expected", name);
    endtask
    function automatic logic [95:0] outs();
        return 96'({busy, done, error, mem_addr, mem_we, mem_wdata, bus.request, bus.begin_trans_out,
                    bus.addr_data_out, bus.burst_size_out, bus.read_n_write, bus.data_valid_out,
                    bus.end_trans_out});
    endfunction
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic start_xfer(input logic d, input logic [31:0] ba, input logic [8:0] ma,
                              input logic [9:0] bs, input logic [7:0] bu);
        tick();
        dir = d; bus_start_addr = ba; mem_start_addr = ma; block_size = bs; burst_size = bu;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic wait_done(string name);
        int k;
        k = 0;
        while (k < 400) begin
            @(negedge clock);
            if (done) break;
            k++;
        end
        chk(name, 96'(done), 96'(1));
    endtask
    task automatic check_empty(string name);
        chk({name, "_begin_left"}, 96'(beg_q.size()), 96'(0));
        chk({name, "_memwr_left"}, 96'(mw_q.size()), 96'(0));
        chk({name, "_wrdata_left"}, 96'(wd_q.size()), 96'(0));
        chk({name, "_done_left"}, 96'(de_q.size()), 96'(0));
    endtask
    task automatic clr_counts();
        et_cnt = 0; gap_cnt = 0; req_cnt = 0; stall_chk = 0;
    endtask
    // local memory: synchronous read, write on mem_we
    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hBEEF_0000 + 32'(i);
        forever begin
            @(posedge clock);
            mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end
    // read-burst slave: supplies f(address) words, optionally errors on word 1 of a chosen burst
    initial begin
        logic [31:0] a;
        int nw, bi;
        bus.addr_data_in = '0; bus.data_valid_in = 1'b0; bus.end_trans_in = 1'b0; bus.error_in = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.begin_trans_out && bus.read_n_write) begin
                a = bus.addr_data_out;
                nw = int'(bus.burst_size_out) + 1;
                bi = rd_burst;
                rd_burst++;
                for (int i = 0; i < nw; i++) begin
                    tick();
                    if (bi == err_burst && i == 1) begin
                        bus.error_in = 1'b1; bus.data_valid_in = 1'b0; bus.end_trans_in = 1'b0;
                        break;
                    end
                    bus.data_valid_in = 1'b1;
                    bus.addr_data_in = f(a + 32'(4 * i));
                    bus.end_trans_in = i == nw - 1;
                end
                tick();
                bus.data_valid_in = 1'b0; bus.end_trans_in = 1'b0; bus.error_in = 1'b0; bus.addr_data_in = '0;
            end
        end
    end
    // write slave: counts accepted words and stalls two cycles once stall_k words are in
    initial begin
        int sc;
        logic nb;
        sc = 0;
        bus.busy_in = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.data_valid_out && !bus.busy_in) wr_acc++;
            if (sc == 0 && stall_k >= 0 && wr_acc == stall_k && bus.data_valid_out) begin
                sc = 2;
                stall_k = -1;
            end
            nb = sc > 0;
            if (sc > 0) sc--;
            tick();
            bus.busy_in = nb;
        end
    end
    // monitor: pops expectations whenever the DUT presents a begin, memory write, bus write word or done
    initial begin
        logic ps;
        logic [31:0] pd;
        ps = 1'b0;
        pd = '0;
        forever begin
            @(negedge clock);
            if (bus.begin_trans_out) begin
                if (beg_q.size() == 0) extra("begin");
                else chk("begin", 96'({bus.addr_data_out, bus.burst_size_out, bus.read_n_write}), 96'(beg_q.pop_front()));
            end
            if (mem_we) begin
                if (mw_q.size() == 0) extra("mem_write");
                else chk("mem_write", 96'({mem_addr, mem_wdata}), 96'(mw_q.pop_front()));
            end
            if (bus.data_valid_out && !bus.busy_in) begin
                if (wd_q.size() == 0) extra("wr_data");
                else chk("wr_data", 96'(bus.addr_data_out), 96'(wd_q.pop_front()));
            end
            if (done) begin
                if (de_q.size() == 0) extra("done");
                else chk("done_error", 96'(error), 96'(de_q.pop_front()));
            end
            if (ps) begin
                chk("stall_hold", 96'({bus.data_valid_out, bus.addr_data_out}), 96'({1'b1, pd}));
                stall_chk++;
            end
            ps = bus.data_valid_out && bus.busy_in;
            pd = bus.addr_data_out;
            if (bus.end_trans_out) et_cnt++;
            if (busy && !bus.request && !done) gap_cnt++;
            if (bus.request) req_cnt++;
        end
    end
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        reset = 1'b1; start = 1'b0; dir = 1'b0;
        bus_start_addr = '0; mem_start_addr = '0; block_size = '0; burst_size = '0;
        repeat (3) tick();
        @(negedge clock);
        chk("reset_outputs", outs(), 96'(0));
        tick();
        reset = 1'b0;
        // 1: two 4-word read bursts
        clr_counts();
        beg_q.push_back({32'h1000, 8'd3, 1'b1});
        beg_q.push_back({32'h1010, 8'd3, 1'b1});
        for (int i = 0; i < 8; i++) mw_q.push_back({9'(i), f(32'h1000 + 32'(4 * i))});
        de_q.push_back(1'b0);
        start_xfer(1'b0, 32'h1000, 9'd0, 10'd8, 8'd3);
        @(negedge clock);
        chk("t1_busy", 96'(busy), 96'(1));
        wait_done("t1_done");
        tick();
        chk("t1_req_gaps", 96'(gap_cnt), 96'(2));
        check_empty("t1");
        // 2: 6-word write burst wrapping 511->0 with a 2-cycle stall
        clr_counts();
        stall_k = wr_acc + 2;
        beg_q.push_back({32'h6000, 8'd5, 1'b0});
        wd_q.push_back(32'hBEEF_01FC); wd_q.push_back(32'hBEEF_01FD);
        wd_q.push_back(32'hBEEF_01FE); wd_q.push_back(32'hBEEF_01FF);
        wd_q.push_back(32'h5A5A_1000); wd_q.push_back(32'h5A5A_1004);
        de_q.push_back(1'b0);
        start_xfer(1'b1, 32'h6000, 9'd508, 10'd6, 8'd7);
        wait_done("t2_done");
        tick();
        chk("t2_end_trans", 96'(et_cnt), 96'(1));
        chk("t2_stall_cycles", 96'(stall_chk), 96'(2));
        chk("t2_req_gaps", 96'(gap_cnt), 96'(1));
        check_empty("t2");
        // 3: bursts of 2,2,1
        clr_counts();
        beg_q.push_back({32'h2000, 8'd1, 1'b1});
        beg_q.push_back({32'h2008, 8'd1, 1'b1});
        beg_q.push_back({32'h2010, 8'd0, 1'b1});
        for (int i = 0; i < 5; i++) mw_q.push_back({9'(100 + i), f(32'h2000 + 32'(4 * i))});
        de_q.push_back(1'b0);
        start_xfer(1'b0, 32'h2000, 9'd100, 10'd5, 8'd1);
        wait_done("t3_done");
        tick();
        chk("t3_req_gaps", 96'(gap_cnt), 96'(3));
        check_empty("t3");
        // 4: empty block
        clr_counts();
        de_q.push_back(1'b0);
        start_xfer(1'b0, 32'h7000, 9'd0, 10'd0, 8'd5);
        @(negedge clock);
        chk("t4_done_next_cycle", 96'({done, busy}), 96'(2'b11));
        tick();
        tick();
        chk("t4_no_request", 96'(req_cnt), 96'(0));
        check_empty("t4");
        // 5: bus error on the second read burst
        clr_counts();
        err_burst = rd_burst + 1;
        beg_q.push_back({32'h3000, 8'd3, 1'b1});
        beg_q.push_back({32'h3010, 8'd3, 1'b1});
        for (int i = 0; i < 5; i++) mw_q.push_back({9'(200 + i), f(32'h3000 + 32'(4 * i))});
        de_q.push_back(1'b1);
        start_xfer(1'b0, 32'h3000, 9'd200, 10'd8, 8'd3);
        wait_done("t5_done");
        chk("t5_req_dropped", 96'(bus.request), 96'(0));
        tick();
        tick();
        @(negedge clock);
        chk("t5_error_sticky", 96'({error, busy, bus.request}), 96'(3'b100));
        err_burst = -1;
        check_empty("t5");
        // 6: reset during write data phase, then a normal write
        clr_counts();
        beg_q.push_back({32'h4000, 8'd3, 1'b0});
        for (int i = 0; i < 4; i++) wd_q.push_back(32'hBEEF_000A + 32'(i));
        start_xfer(1'b1, 32'h4000, 9'd10, 10'd4, 8'd3);
        @(negedge clock);
        chk("t6_error_cleared", 96'(error), 96'(0));
        begin
            int k;
            k = 0;
            while (!bus.data_valid_out && k < 50) begin
                @(negedge clock);
                k++;
            end
            chk("t6_wr_phase", 96'(bus.data_valid_out), 96'(1));
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("t6_reset_outputs", outs(), 96'(0));
        chk("t6_no_end_trans", 96'(et_cnt), 96'(0));
        wd_q.delete();
        clr_counts();
        beg_q.push_back({32'h5000, 8'd2, 1'b0});
        for (int i = 0; i < 3; i++) wd_q.push_back(32'hBEEF_0014 + 32'(i));
        de_q.push_back(1'b0);
        start_xfer(1'b1, 32'h5000, 9'd20, 10'd3, 8'd7);
        wait_done("t6_done");
        tick();
        chk("t6_end_trans", 96'(et_cnt), 96'(1));
        check_empty("t6");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
